// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_LD
  } owner_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // A byte address faults when misaligned or above the 2**addr_w word window.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and BRAM signals of the instruction-memory arbiter.
interface imem_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              fetch_req_valid;
  logic              fetch_req_ready;
  logic [31:0]       fetch_addr;
  logic              fetch_rsp_valid;
  logic [31:0]       fetch_rsp_data;
  logic              fetch_rsp_err;

  logic              ld_req_valid;
  logic              ld_req_ready;
  logic              ld_we;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_wdata;
  logic [3:0]        ld_wstrb;
  logic              ld_lock;
  logic              ld_rsp_valid;
  logic [31:0]       ld_rsp_data;
  logic              ld_rsp_err;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Requesters plus the BRAM itself form the surrounding environment.
  modport master (
    output fetch_req_valid, fetch_addr,
    output ld_req_valid, ld_we, ld_addr, ld_wdata, ld_wstrb, ld_lock,
    output mem_rdata,
    input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
    input  ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  fetch_req_valid, fetch_addr,
    input  ld_req_valid, ld_we, ld_addr, ld_wdata, ld_wstrb, ld_lock,
    input  mem_rdata,
    output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
    output ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arb_prio.sv
// Grant selection between fetch and loader with a loader starvation counter.
module imem_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_valid,
  input  logic ld_valid,
  input  logic ld_lock,
  output logic grant_fetch,
  output logic grant_ld
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved     = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_ld    = !rst && ld_valid && (ld_lock || !fetch_valid || starved);
  assign grant_fetch = !rst && fetch_valid && !ld_lock && !grant_ld;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!ld_valid || grant_ld) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction BRAM between fetch and the loader/debug port.
module imem_arbiter #(
  parameter int          ADDR_W       = 10,
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] NOP_INSTR    = imem_pkg::NOP_INSTR
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);
  import imem_pkg::*;

  logic   grant_fetch;
  logic   grant_ld;
  logic   fault_fetch;
  logic   fault_ld;
  owner_e owner_q;
  logic   err_q;
  logic   wr_q;
  logic   fetch_live;
  logic   ld_live;

  assign fault_fetch = addr_fault(bus.fetch_addr, ADDR_W);
  assign fault_ld    = addr_fault(bus.ld_addr, ADDR_W);

  imem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (bus.fetch_req_valid),
    .ld_valid    (bus.ld_req_valid),
    .ld_lock     (bus.ld_lock),
    .grant_fetch (grant_fetch),
    .grant_ld    (grant_ld)
  );

  assign bus.fetch_req_ready = grant_fetch;
  assign bus.ld_req_ready    = grant_ld;

  // Faulting requests are granted but never reach the BRAM.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'd0;
    if (grant_ld) begin
      bus.mem_en    = !fault_ld;
      bus.mem_addr  = bus.ld_addr[ADDR_W+1:2];
      bus.mem_wdata = bus.ld_wdata;
      if (!fault_ld && bus.ld_we) begin
        bus.mem_we = bus.ld_wstrb;
      end
    end else if (grant_fetch) begin
      bus.mem_en   = !fault_fetch;
      bus.mem_addr = bus.fetch_addr[ADDR_W+1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else if (grant_ld) begin
      owner_q <= OWN_LD;
      err_q   <= fault_ld;
      wr_q    <= bus.ld_we;
    end else if (grant_fetch) begin
      owner_q <= OWN_FETCH;
      err_q   <= fault_fetch;
      wr_q    <= 1'b0;
    end else begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end
  end

  // Gating with rst drops a response whose grant preceded a reset cycle.
  assign fetch_live = !rst && (owner_q == OWN_FETCH);
  assign ld_live    = !rst && (owner_q == OWN_LD);

  assign bus.fetch_rsp_valid = fetch_live;
  assign bus.fetch_rsp_err   = fetch_live && err_q;
  assign bus.fetch_rsp_data  = !fetch_live ? 32'd0 : (err_q ? NOP_INSTR : bus.mem_rdata);

  assign bus.ld_rsp_valid = ld_live;
  assign bus.ld_rsp_err   = ld_live && err_q;
  assign bus.ld_rsp_data  = (ld_live && !err_q && !wr_q) ? bus.mem_rdata : 32'd0;

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port instruction BRAM between the core fetch stage (read-only) and a program-loader/debug port (read/write).
- Arbitrates requests, drives the BRAM port, and routes the 1-cycle-latency read data back to the winning requester.
- Sits between the fetch stage and the instruction memory. A loader lock input lets the loader hold off fetch during program download.

Parameters:
- ADDR_W, 10, word-address width of the BRAM (depth = 2**ADDR_W words).
- STARVE_LIMIT, 4, consecutive cycles the loader may wait under contention before it is forced a grant.
- NOP_INSTR, 32'h0000_0013, data returned on a faulting fetch (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- fetch_req_valid  in  1  fetch request.
- fetch_req_ready  out  1  fetch request accepted this cycle.
- fetch_addr  in  32  byte address (PC).
- fetch_rsp_valid  out  1  one-cycle pulse; fetch data valid.
- fetch_rsp_data  out  32  instruction word.
- fetch_rsp_err  out  1  qualifies fetch_rsp_valid; misaligned or out-of-range fetch.
- ld_req_valid  in  1  loader request.
- ld_req_ready  out  1  loader request accepted this cycle.
- ld_we  in  1  1 = write, 0 = read.
- ld_addr  in  32  byte address.
- ld_wdata  in  32  write data.
- ld_wstrb  in  4  byte enables for writes.
- ld_lock  in  1  while high, fetch is never granted.
- ld_rsp_valid  out  1  one-cycle pulse; read data or write acknowledge.
- ld_rsp_data  out  32  read data (0 for writes).
- ld_rsp_err  out  1  qualifies ld_rsp_valid; out-of-range or misaligned access.
- mem_en  out  1  BRAM enable.
- mem_we  out  4  BRAM byte write enables.
- mem_addr  out  ADDR_W  BRAM word address.
- mem_wdata  out  32  BRAM write data.
- mem_rdata  in  32  BRAM read data, valid 1 cycle after mem_en.

Behaviour:
- Reset: all rsp_valid, rsp_err and rsp_data outputs are 0, the starvation counter is 0, and the response-owner pipeline is cleared.
- ready and mem_* outputs are combinational from the current grant. With no grant, mem_en = 0 and mem_we = 0.
- A request is granted in cycle N when valid && ready. The response pulses for exactly one cycle in N+1. There is no response backpressure, so requesters must always accept responses.
- Arbitration, evaluated when both requesters are valid:
  - ld_lock = 1: loader wins.
  - Otherwise, if starve_cnt == STARVE_LIMIT: loader wins.
  - Otherwise: fetch wins.
  - When only one requester is valid, it wins. At most one grant per cycle.
- starve_cnt:
  - Cleared on any loader grant, or whenever ld_req_valid = 0.
  - Incremented when the loader is valid but not granted.
  - Saturates at STARVE_LIMIT.
- ld_lock = 1 forces fetch_req_ready = 0 regardless of loader activity. A fetch response already in flight (granted the previous cycle) is still delivered.
- Address checks, applied to both requesters:
  - Word index = addr[ADDR_W+1:2].
  - Fault if addr[1:0] != 0, or if any bit addr[31:ADDR_W+2] is set.
- A faulting request is still granted, but mem_en = 0 for it. Its response in N+1 has err = 1.
  - Fetch fault: data = NOP_INSTR.
  - Loader fault: data = 0, and no write occurs.
- Loader write: mem_we = ld_wstrb and mem_wdata = ld_wdata in cycle N. ld_rsp_valid pulses in N+1 with data 0, err 0.
- Read data routing: a registered owner tag (none / fetch / loader) plus an err flag captured in N select mem_rdata or the fault value in N+1.
- Back-to-back grants to either requester are allowed every cycle, giving full throughput.
- A loader write followed by a fetch of the same word in the next cycle returns the new data. The BRAM is read-after-write in separate cycles.
- Reset asserted in the cycle after a grant: that response is dropped and no rsp_valid is raised.

Decomposition:
- Shared package imem_pkg:
  - owner_e enum (OWN_NONE, OWN_FETCH, OWN_LD).
  - NOP_INSTR constant.
  - A function addr_fault(addr, ADDR_W) returning the fault bit.
- One natural sub-module: imem_arb_prio. It holds the starvation counter and the grant logic, and outputs grant_fetch / grant_ld. The top level handles address checks, the BRAM drive, and the response pipeline.

Test Plan:
- Fetch-only stream to addresses 0x0, 0x4, 0x8 with the BRAM preloaded with 0xA, 0xB, 0xC -> fetch_rsp_valid each cycle with data 0xA, 0xB, 0xC, one cycle after each grant, err 0.
- Both requesters valid continuously, ld_lock = 0, STARVE_LIMIT = 4 -> 4 fetch grants, then 1 loader grant, repeating; starve_cnt returns to 0 after the loader grant.
- ld_lock = 1, loader writes 0xDEADBEEF, wstrb 4'b1111 to 0x10 while fetch is valid -> fetch_req_ready stays 0. Then release the lock and fetch 0x10 -> data 0xDEADBEEF.
- Fetch to 0x6 (misaligned) and to 0x1000 (out of range, ADDR_W = 10) -> mem_en = 0, fetch_rsp_data = 0x00000013, fetch_rsp_err = 1.
- Partial write: wstrb 4'b0010, wdata 0x0000AB00 over 0x11223344 -> loader read returns 0x1122AB44.
- Assert rst the cycle after a fetch grant -> no fetch_rsp_valid, all outputs 0. First request after reset is granted normally.
